car_collision_scanner: RTL and testbench
========================================

# car_collision_scanner

Per-frame collision scanner that reads the grid positions published by the lane car movers and compares them against the frog's position. On each `scan_start` pulse it walks the car slots one per cycle through an external read-select mux, evaluates row and column overlap with wrap-around, then reports a registered hit result. It sits between the car movers and the game-state controller, which uses `hit` to kill the frog.

## Interface
Parameters:
- `NUM_CARS`, default 8: number of car slots scanned; min 1, max 16.
- `POSITIONS`, default 20: grid columns per row (640 / 32).
- `STEP_SIZE`, default 32: pixels per grid column; power of two.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `reset_n`  in  1: synchronous, active-low reset.
- `scan_start`  in  1: one-cycle request to start a scan, normally on frame tick.
- `frog_x`  in  10: frog pixel x, sampled on accepted `scan_start`.
- `frog_y`  in  10: frog pixel y, sampled on accepted `scan_start`.
- `car_sel`  out  clog2(NUM_CARS): slot index driven to the external car mux.
- `car_valid_in`  in  1: selected slot holds an active car.
- `car_pos_in`  in  5: selected car column index, 0..POSITIONS-1.
- `car_y_in`  in  10: selected car pixel y.
- `car_len_in`  in  2: selected car length code; occupies `car_len_in`+1 columns.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle pulse when the scan result is updated.
- `hit`  out  1: last completed scan found an overlap; held until the next `done`.
- `hit_index`  out  clog2(NUM_CARS): lowest overlapping slot index; 0 when `hit`=0.

## Operation
- FSM states: IDLE, SCAN, REPORT.
- IDLE: `scan_start`=1 latches `frog_y` and frog column `fc = frog_x / STEP_SIZE` (6 bits). It clears the internal hit accumulator, sets `car_sel`=0, and moves to SCAN.
- SCAN: the mux is combinational outside the block, so `car_*_in` are valid in the same cycle as `car_sel`. Each cycle evaluates slot `car_sel`.
  - Overlap requires all three: `car_valid_in`=1, `car_y_in == latched frog_y` (exact match; rows are grid-aligned), and column match.
  - Column match: `diff = (fc >= car_pos_in) ? fc - car_pos_in : fc + POSITIONS - car_pos_in`, computed 6 bits wide. Match when `diff <= car_len_in`. This covers a car wrapping from column 19 to column 0.
  - `fc >= POSITIONS` (frog off-grid, `frog_x` >= 640) never matches.
  - First overlap records its index; later overlaps do not overwrite it.
  - If `car_sel == NUM_CARS-1`, go to REPORT; otherwise increment `car_sel`.
- REPORT: copy the accumulator to `hit`/`hit_index`, pulse `done`, and return to IDLE with `car_sel`=0.
- `scan_start` in SCAN or REPORT is ignored and not queued.
- `frog_x`/`frog_y` changes after acceptance do not affect the current scan.
- Reset values: `car_sel`=0, `busy`=0, `done`=0, `hit`=0, `hit_index`=0, state IDLE, accumulator cleared.
- Reset mid-scan aborts the scan. No `done` is issued, and the previous `hit` is cleared.

## Timing
- Cycle 0: `scan_start` sampled high in IDLE.
- Cycles 1..NUM_CARS: SCAN with `busy`=1. `car_sel` = 0..NUM_CARS-1, one slot per cycle.
- Cycle NUM_CARS+1: REPORT. `done`=1 for exactly one cycle, with `hit`/`hit_index` updated on the same edge. `busy`=1.
- Cycle NUM_CARS+2: IDLE, `busy`=0. A new `scan_start` is accepted here.
- Scan latency is NUM_CARS+1 cycles from request to `done`; 9 for the default configuration.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `scan_start`=1 -> all outputs 0. Release -> scan starts on the next `scan_start`.
- Direct hit: frog (96,224); slot 3 = pos 2, y 224, len 1, valid; other slots invalid -> `done` at cycle 9, `hit`=1, `hit_index`=3.
- Wrap-around: frog (0,160); slot 5 = pos 19, y 160, len 1 -> hit, index 5. Same setup with len 0 -> `hit`=0.
- Near misses, each with `hit`=0:
  - row differs by 32;
  - column one past the tail (pos 2, len 1, frog column 4);
  - `car_valid_in`=0;
  - frog_x=640.
- Priority and busy: slots 1 and 6 both overlap -> `hit_index`=1. A second `scan_start` at cycle 4 -> ignored, exactly one `done`.
- Reset mid-scan: assert `reset_n`=0 at cycle 5 of a hitting scan -> no `done`, `hit`=0, `busy`=0. The next full scan reports normally.

Source files
------------

// File: rtl/car_collision_scanner.sv
// ---------------------------------------------------------------------------
// car_collision_scanner
//
// Per-frame collision scanner. On an accepted scan_start it latches the frog
// position, walks the car slots one per cycle through an external read-select
// mux and checks each slot for row and column overlap with the frog. Column
// overlap handles a car whose tail wraps from the last grid column back to
// column 0. When the walk finishes it publishes a registered hit result and a
// one-cycle done pulse for the game-state controller.
//
// Ports
//   clk           system clock
//   reset_n       synchronous active-low reset
//   scan_start    one-cycle scan request (ignored while busy)
//   frog_x/y      frog pixel position, sampled on an accepted request
//   car_sel       slot index driven to the external car mux
//   car_valid_in  selected slot holds an active car
//   car_pos_in    selected car head column, 0..POSITIONS-1
//   car_y_in      selected car pixel row
//   car_len_in    selected car length code (occupies len+1 columns)
//   busy          scan in progress (SCAN or REPORT)
//   done          one-cycle pulse when hit/hit_index are updated
//   hit           last completed scan found an overlap
//   hit_index     lowest overlapping slot, 0 when hit is 0
// ---------------------------------------------------------------------------
module car_collision_scanner #(
   parameter  int NUM_CARS  = 8,
   parameter  int POSITIONS = 20,
   parameter  int STEP_SIZE = 32,
   localparam int SEL_W     = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             scan_start,
   input  logic [9:0]       frog_x,
   input  logic [9:0]       frog_y,
   output logic [SEL_W-1:0] car_sel,
   input  logic             car_valid_in,
   input  logic [4:0]       car_pos_in,
   input  logic [9:0]       car_y_in,
   input  logic [1:0]       car_len_in,
   output logic             busy,
   output logic             done,
   output logic             hit,
   output logic [SEL_W-1:0] hit_index
);

   localparam int               SHIFT = $clog2(STEP_SIZE);
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_CARS - 1);
   localparam logic [5:0]       POS6  = 6'(POSITIONS);

   typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

   state_t           state, state_nxt;
   logic [5:0]       frog_col;
   logic [9:0]       frog_row;
   logic             acc_hit;
   logic [SEL_W-1:0] acc_idx;

   // frog column from pixel x; saturate so a far off-grid x cannot alias
   // back onto the grid through truncation to 6 bits
   logic [9:0] col_full;
   logic [5:0] fc_in;
   assign col_full = frog_x >> SHIFT;
   assign fc_in    = (col_full > 10'd63) ? 6'd63 : col_full[5:0];

   // distance from the car head forward to the frog column, modulo the row
   // width; 6-bit wraparound arithmetic is exact because the true result is
   // always below POSITIONS
   logic [5:0] pos6;
   logic [5:0] diff;
   logic       col_hit;
   logic       slot_hit;

   assign pos6 = {1'b0, car_pos_in};

   always_comb begin
      diff = 6'd0;
      if (frog_col >= pos6) diff = frog_col - pos6;
      else                  diff = frog_col + POS6 - pos6;
   end

   assign col_hit  = (frog_col < POS6) && (diff <= {4'b0, car_len_in});
   assign slot_hit = car_valid_in && (car_y_in == frog_row) && col_hit;

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (scan_start) state_nxt = SCAN;
         SCAN:    if (car_sel == LAST) state_nxt = REPORT;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         car_sel   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit       <= 1'b0;
         hit_index <= '0;
         frog_col  <= 6'd0;
         frog_row  <= 10'd0;
         acc_hit   <= 1'b0;
         acc_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (scan_start) begin
                  frog_row <= frog_y;
                  frog_col <= fc_in;
                  acc_hit  <= 1'b0;
                  acc_idx  <= '0;
                  car_sel  <= '0;
                  busy     <= 1'b1;
               end
            end
            SCAN: begin
               // first overlap wins; later slots never overwrite the index
               if (slot_hit && !acc_hit) begin
                  acc_hit <= 1'b1;
                  acc_idx <= car_sel;
               end
               if (car_sel == LAST) begin
                  // fold the final slot in here so hit/done are already
                  // valid during the REPORT cycle
                  hit       <= acc_hit | slot_hit;
                  hit_index <= acc_hit  ? acc_idx :
                               slot_hit ? car_sel : '0;
                  done      <= 1'b1;
               end else begin
                  car_sel <= car_sel + SEL_W'(1);
               end
            end
            REPORT: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               car_sel <= '0;
            end
            default: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_car_collision_scanner.sv
// ---------------------------------------------------------------------------
// tb_car_collision_scanner
//
// Directed bench for car_collision_scanner (default parameters). A small
// array of car slots models the external read-select mux. A table of scan
// vectors is applied in a loop; reset behaviour and the mid-scan reset are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_car_collision_scanner;

   localparam int NUM_CARS = 8;
   localparam int SEL_W    = 3;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             scan_start;
   logic [9:0]       frog_x, frog_y;
   logic [SEL_W-1:0] car_sel;
   logic             car_valid_in;
   logic [4:0]       car_pos_in;
   logic [9:0]       car_y_in;
   logic [1:0]       car_len_in;
   logic             busy, done, hit;
   logic [SEL_W-1:0] hit_index;

   // car slot storage behind the mux
   logic       cv [NUM_CARS];
   logic [4:0] cp [NUM_CARS];
   logic [9:0] cy [NUM_CARS];
   logic [1:0] cl [NUM_CARS];

   assign car_valid_in = cv[car_sel];
   assign car_pos_in   = cp[car_sel];
   assign car_y_in     = cy[car_sel];
   assign car_len_in   = cl[car_sel];

   always #5 clk = ~clk;

   car_collision_scanner #(.NUM_CARS(NUM_CARS), .POSITIONS(20), .STEP_SIZE(32)) dut (
      .clk(clk), .reset_n(reset_n), .scan_start(scan_start),
      .frog_x(frog_x), .frog_y(frog_y), .car_sel(car_sel),
      .car_valid_in(car_valid_in), .car_pos_in(car_pos_in),
      .car_y_in(car_y_in), .car_len_in(car_len_in),
      .busy(busy), .done(done), .hit(hit), .hit_index(hit_index)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      string name;
      int    fx, fy;
      int    sa; logic va; int pa, ya, la;   // slot A (sa<0: unused)
      int    sb; int pb, yb, lb;             // slot B, always valid when used
      int    eh, ei;                         // expected hit / hit_index
      int    extra;                          // cycle of a stray scan_start, 0 none
   } vec_t;

   task automatic clear_cars();
      for (int i = 0; i < NUM_CARS; i++) begin
         cv[i] = 1'b0; cp[i] = 5'd0; cy[i] = 10'd0; cl[i] = 2'd0;
      end
   endtask

   // one scan: request, watch 14 cycles, check done count/latency/result
   task automatic do_scan(input string nm, input int fx, input int fy,
                          input int eh, input int ei, input int extra);
      int dcnt, dlat, hv, iv, busy_end;
      dcnt = 0; dlat = 0; hv = -1; iv = -1; busy_end = -1;
      @(negedge clk);
      frog_x = 10'(fx); frog_y = 10'(fy); scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      // disturb the frog inputs; the latched copy must be used
      frog_x = 10'(fx) ^ 10'h155; frog_y = 10'(fy) ^ 10'h0a0;
      for (int lat = 1; lat <= 14; lat++) begin
         if (lat == 1) chk({nm, " busy@1"}, int'(busy), 1);
         if (done) begin
            dcnt++;
            if (dcnt == 1) begin dlat = lat; hv = int'(hit); iv = int'(hit_index); end
         end
         if (lat == NUM_CARS + 2) busy_end = int'(busy);
         scan_start = (lat == extra);
         @(negedge clk);
      end
      scan_start = 1'b0;
      chk({nm, " done_count"}, dcnt, 1);
      chk({nm, " latency"}, dlat, NUM_CARS + 1);
      chk({nm, " hit"}, hv, eh);
      chk({nm, " hit_index"}, iv, ei);
      chk({nm, " busy_after"}, busy_end, 0);
      chk({nm, " hit_held"}, int'(hit), eh);
   endtask

   task automatic run_vec(input vec_t v);
      clear_cars();
      if (v.sa >= 0) begin
         cv[v.sa] = v.va; cp[v.sa] = 5'(v.pa); cy[v.sa] = 10'(v.ya); cl[v.sa] = 2'(v.la);
      end
      if (v.sb >= 0) begin
         cv[v.sb] = 1'b1; cp[v.sb] = 5'(v.pb); cy[v.sb] = 10'(v.yb); cl[v.sb] = 2'(v.lb);
      end
      do_scan(v.name, v.fx, v.fy, v.eh, v.ei, v.extra);
   endtask

   vec_t vecs[$];

   initial begin
      // name, fx, fy, sa, va, pa, ya, la, sb, pb, yb, lb, eh, ei, extra
      vecs.push_back('{"direct",     96, 224, 3, 1'b1,  2, 224, 1, -1,  0,   0, 0, 1, 3, 0});
      vecs.push_back('{"wrap_len1",   0, 160, 5, 1'b1, 19, 160, 1, -1,  0,   0, 0, 1, 5, 0});
      vecs.push_back('{"wrap_len0",   0, 160, 5, 1'b1, 19, 160, 0, -1,  0,   0, 0, 0, 0, 0});
      vecs.push_back('{"row_off",    96, 224, 3, 1'b1,  2, 192, 1, -1,  0,   0, 0, 0, 0, 0});
      vecs.push_back('{"past_tail", 128, 224, 3, 1'b1,  2, 224, 1, -1,  0,   0, 0, 0, 0, 0});
      vecs.push_back('{"invalid",    96, 224, 3, 1'b0,  2, 224, 1, -1,  0,   0, 0, 0, 0, 0});
      vecs.push_back('{"off_grid",  640, 224, 2, 1'b1, 19, 224, 3, -1,  0,   0, 0, 0, 0, 0});
      vecs.push_back('{"priority",   96, 224, 1, 1'b1,  3, 224, 0,  6,  1, 224, 3, 1, 1, 4});
      vecs.push_back('{"last_slot", 608,   0, 7, 1'b1, 18,   0, 1, -1,  0,   0, 0, 1, 7, 0});
      vecs.push_back('{"slot0_len3",639,  64, 0, 1'b1, 16,  64, 3, -1,  0,   0, 0, 1, 0, 0});
      vecs.push_back('{"wrap_len3",  37, 288, 2, 1'b1, 18, 288, 3, -1,  0,   0, 0, 1, 2, 0});
      vecs.push_back('{"wrap_miss",  64, 288, 2, 1'b1, 18, 288, 3, -1,  0,   0, 0, 0, 0, 0});
      vecs.push_back('{"inv_first",  96, 224, 1, 1'b0,  3, 224, 0,  4,  3, 224, 0, 1, 4, 0});
   end

   initial begin
      int dcnt;
      clear_cars();
      reset_n = 1'b0; scan_start = 1'b1; frog_x = 10'd96; frog_y = 10'd224;

      // reset held with scan_start high: everything stays at zero
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst busy", int'(busy), 0);
         chk("rst done", int'(done), 0);
         chk("rst hit", int'(hit), 0);
         chk("rst hit_index", int'(hit_index), 0);
         chk("rst car_sel", int'(car_sel), 0);
      end
      scan_start = 1'b0; reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst idle", int'(busy), 0);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // reset mid-scan after a scan that left hit=1
      run_vec(vecs[0]);
      @(negedge clk);
      frog_x = 10'd96; frog_y = 10'd224; scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      repeat (4) @(negedge clk);          // now in cycle 5
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst done", int'(done), 0);
      chk("midrst hit", int'(hit), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst car_sel", int'(car_sel), 0);
      reset_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("midrst no_done", dcnt, 0);
      chk("midrst hit_stays", int'(hit), 0);
      do_scan("after_midrst", 96, 224, 1, 3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // absolute watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
